// File: rtl/branch_update_ctrl.sv
// -----------------------------------------------------------------------------
// branch_update_ctrl
//
// Purpose:
//   Sits between EX-stage branch resolution and the branch prediction buffer.
//   Each resolved branch is compared with the prediction captured at fetch.
//   A mispredict raises a registered redirect pulse and a multi-cycle flush
//   to the front end, and queues a predictor update. Queued updates drain one
//   per cycle through the predictor's update port. Branch and mispredict
//   statistics are kept and saturate at all-ones.
//
// Build option:
//   BPU_UPDATE_ALL_EN - when defined, every accepted non-discarded resolution
//                       pushes an update (correct predictions train the
//                       predictor too). When undefined, only mispredicts
//                       push updates.
//
// Parameters:
//   FIFO_DEPTH   - update queue entries (power of two, >= 2)
//   FLUSH_CYCLES - cycles flush_o stays high per mispredict (>= 1)
//
// Ports:
//   clk, rst_n                - clock (rising edge), synchronous active-low reset
//   resolve_valid_i/ready_o   - resolution handshake (ready = queue not full)
//   resolve_pc_i/taken_i/target_i - resolved branch PC, direction, target
//   pred_hit_i/pred_target_i  - prediction captured at fetch
//   upd_valid_o/ready_i       - predictor update handshake (valid drives miss)
//   upd_taken_o/addr_o/target_o - queue head (zero when queue empty)
//   flush_o                   - kill wrong-path instructions in IF/ID
//   redirect_valid_o/pc_o     - one-cycle PC redirect and corrected PC
//   stat_branch_o/mispred_o   - saturating statistics
// -----------------------------------------------------------------------------
module branch_update_ctrl #(
   parameter int FIFO_DEPTH   = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        resolve_valid_i,
   output logic        resolve_ready_o,
   input  logic [31:0] resolve_pc_i,
   input  logic        resolve_taken_i,
   input  logic [31:0] resolve_target_i,
   input  logic        pred_hit_i,
   input  logic [31:0] pred_target_i,
   output logic        upd_valid_o,
   input  logic        upd_ready_i,
   output logic        upd_taken_o,
   output logic [31:0] upd_addr_o,
   output logic [31:0] upd_target_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] stat_branch_o,
   output logic [31:0] stat_mispred_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES);

   typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

   state_t            r_state, w_state_next;
   logic [FC_W-1:0]   r_flush_cnt, w_flush_cnt_next;

   logic [31:0]       r_mem_pc     [FIFO_DEPTH];
   logic              r_mem_taken  [FIFO_DEPTH];
   logic [31:0]       r_mem_target [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              r_redirect_valid;
   logic [31:0]       r_redirect_pc;
   logic [31:0]       r_stat_branch, r_stat_mispred;

   logic              w_accept, w_live, w_mispred, w_push, w_pop, w_empty;
   logic [31:0]       w_aligned_target, w_correct_pc;
   logic              w_unused;

   // Low two target bits never participate in comparison or redirect.
   assign w_unused = ^{pred_target_i[1:0], resolve_target_i[1:0]};

   assign w_empty          = (r_count == '0);
   assign resolve_ready_o  = (r_count != FULL_CNT);
   assign w_accept         = resolve_valid_i && resolve_ready_o;
   // Resolutions accepted during FLUSH are wrong-path and are dropped.
   assign w_live           = w_accept && (r_state == ST_IDLE);
   assign w_aligned_target = {resolve_target_i[31:2], 2'b00};
   assign w_mispred        = (resolve_taken_i != pred_hit_i) ||
                             (resolve_taken_i && pred_hit_i &&
                              (resolve_target_i[31:2] != pred_target_i[31:2]));
   assign w_correct_pc     = resolve_taken_i ? w_aligned_target
                                             : (resolve_pc_i + 32'd4);
`ifdef BPU_UPDATE_ALL_EN
   assign w_push           = w_live;
`else
   assign w_push           = w_live && w_mispred;
`endif
   assign w_pop            = upd_valid_o && upd_ready_i;

   // Queue head drives the predictor port; forced to zero while empty.
   assign upd_valid_o  = !w_empty;
   assign upd_taken_o  = w_empty ? 1'b0  : r_mem_taken[r_rd_ptr];
   assign upd_addr_o   = w_empty ? 32'd0 : r_mem_pc[r_rd_ptr];
   assign upd_target_o = w_empty ? 32'd0 : r_mem_target[r_rd_ptr];

   // ---------------- flush FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_flush_cnt <= w_flush_cnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      flush_o          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_live && w_mispred) begin
               w_state_next     = ST_FLUSH;
               w_flush_cnt_next = FC_LOAD;
            end
         end
         ST_FLUSH: begin
            flush_o = 1'b1;
            if (r_flush_cnt <= FC_W'(1)) begin
               w_state_next     = ST_IDLE;
               w_flush_cnt_next = '0;
            end else begin
               w_flush_cnt_next = r_flush_cnt - FC_W'(1);
            end
         end
         default: begin
            w_state_next     = ST_IDLE;
            w_flush_cnt_next = '0;
         end
      endcase
   end

   // ---------------- update queue ----------------
   // Storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]     <= resolve_pc_i;
         r_mem_taken[r_wr_ptr]  <= resolve_taken_i;
         r_mem_target[r_wr_ptr] <= w_aligned_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------- redirect and statistics ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_stat_branch    <= '0;
         r_stat_mispred   <= '0;
      end else begin
         r_redirect_valid <= w_live && w_mispred;
         if (w_live && w_mispred) r_redirect_pc <= w_correct_pc;
         if (w_live && (r_stat_branch != '1))
            r_stat_branch <= r_stat_branch + 32'd1;
         if (w_live && w_mispred && (r_stat_mispred != '1))
            r_stat_mispred <= r_stat_mispred + 32'd1;
      end
   end

   assign redirect_valid_o = r_redirect_valid;
   assign redirect_pc_o    = r_redirect_pc;
   assign stat_branch_o    = r_stat_branch;
   assign stat_mispred_o   = r_stat_mispred;

endmodule
